display_source_sel: RTL and testbench

Upstream feeder for the seven-segment digit display stage: generates the `mode` / `msg` pair that the display consumes. It normally shows the selected baud rate. Each byte received or loaded for transmission switches it to data mode for a guaranteed minimum hold time. A one-entry pending buffer keeps back-to-back bytes from flickering past unseen.

---
 rtl/display_source_sel.sv | 121 ++++++++++++
 tb/tb_display_source_sel.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_sel.sv
// Display source selector: shows the baud code, or each received/transmitted
// byte for a guaranteed hold time, with a one-entry pending buffer.
module display_source_sel #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       mode,
    output logic [7:0] msg,
    output logic       data_busy,
    output logic       overrun
);

    localparam logic BAUDRATE_MODE = 1'b0;
    localparam logic DATA_MODE     = 1'b1;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        S_BAUD,
        S_DATA
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] msg_q, msg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_byte_q, pend_byte_d;
    logic       ovr_q, ovr_d;

    logic       ev;
    logic       both;
    logic [7:0] first_byte;

    assign ev         = rx_valid | tx_load;
    assign both       = rx_valid & tx_load;
    assign first_byte = rx_valid ? rx_data : tx_data;

    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_q     <= S_BAUD;
            msg_q       <= 8'h00;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_byte_q <= 8'h00;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_byte_q <= pend_byte_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_byte_d = pend_byte_q;
        ovr_d       = 1'b0;
        unique case (state_q)
            S_BAUD: begin
                if (ev) begin
                    state_d = S_DATA;
                    msg_d   = first_byte;
                    cnt_d   = RELOAD;
                    if (both) begin
                        pend_vld_d  = 1'b1;
                        pend_byte_d = tx_data;
                    end
                end else begin
                    msg_d = {6'b0, baud_sel};
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Newest byte wins the slot; anything displaced is an overrun
                    if (ev) begin
                        pend_vld_d  = 1'b1;
                        pend_byte_d = first_byte;
                        ovr_d       = both | pend_vld_q;
                    end
                end else if (pend_vld_q) begin
                    msg_d      = pend_byte_q;
                    cnt_d      = RELOAD;
                    pend_vld_d = ev;
                    if (ev) begin
                        pend_byte_d = first_byte;
                        ovr_d       = both;
                    end
                end else if (ev) begin
                    msg_d      = first_byte;
                    cnt_d      = RELOAD;
                    pend_vld_d = both;
                    if (both) begin
                        pend_byte_d = tx_data;
                    end
                end else begin
                    state_d = S_BAUD;
                    msg_d   = {6'b0, baud_sel};
                end
            end
        endcase
    end

    assign mode      = (state_q == S_DATA) ? DATA_MODE : BAUDRATE_MODE;
    assign data_busy = (state_q == S_DATA);
    assign msg       = msg_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_display_source_sel.sv
// Randomized bench for display_source_sel against an expiry-time reference
// model, plus directed scenarios with literal expectations.
module tb_display_source_sel;

    localparam int HOLD = 4;
    localparam logic BAUD_M = 1'b0;
    localparam logic DATA_M = 1'b1;
    localparam logic [1:0] SEL_57600 = 2'b01;

    logic       src_clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] baud_sel = SEL_57600;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       mode;
    logic [7:0] msg;
    logic       data_busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    display_source_sel #(
        .HOLD_CYCLES(HOLD),
        .CNT_W(3)
    ) dut (
        .src_clk(src_clk),
        .rst(rst),
        .baud_sel(baud_sel),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .tx_load(tx_load),
        .tx_data(tx_data),
        .mode(mode),
        .msg(msg),
        .data_busy(data_busy),
        .overrun(overrun)
    );

    always #5 src_clk = ~src_clk;

    // Reference: track which byte is on show and the edge at which it expires
    bit         m_init = 0;
    bit         m_data = 0;
    logic [7:0] m_msg = 8'h00;
    bit         m_ovr = 0;
    longint     ecnt = 0;
    longint     m_expire = 0;
    logic [7:0] pend[$];
    logic [7:0] evq[$];

    function automatic void show(input logic [7:0] b);
        m_msg    = b;
        m_data   = 1;
        m_expire = ecnt + HOLD;
    endfunction

    always @(posedge src_clk) begin
        ecnt++;
        m_ovr = 0;
        if (rst) begin
            m_init = 1;
            m_data = 0;
            m_msg  = 8'h00;
            pend.delete();
        end else begin
            evq.delete();
            if (rx_valid) evq.push_back(rx_data);
            if (tx_load) evq.push_back(tx_data);
            if (!m_data) begin
                if (evq.size() > 0) begin
                    show(evq.pop_front());
                    pend = evq;
                end else begin
                    m_msg = {6'b0, baud_sel};
                end
            end else if (ecnt < m_expire) begin
                if (evq.size() > 0) begin
                    m_ovr = (evq.size() > 1) || (pend.size() > 0);
                    pend.delete();
                    pend.push_back(evq[0]);
                end
            end else if (pend.size() > 0) begin
                show(pend.pop_front());
                if (evq.size() > 0) begin
                    pend.push_back(evq[0]);
                    m_ovr = evq.size() > 1;
                end
            end else if (evq.size() > 0) begin
                show(evq.pop_front());
                pend = evq;
            end else begin
                m_data = 0;
                m_msg  = {6'b0, baud_sel};
            end
        end
    end

    always @(negedge src_clk) begin
        if (m_init) begin
            checks++;
            if (mode !== (m_data ? DATA_M : BAUD_M)) begin
                errors++;
                $display("FAIL mode t=%0t got %b want %b", $time, mode, m_data);
            end
            checks++;
            if (msg !== m_msg) begin
                errors++;
                $display("FAIL msg t=%0t got %h want %h", $time, msg, m_msg);
            end
            checks++;
            if (data_busy !== m_data) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, data_busy, m_data);
            end
            checks++;
            if (overrun !== m_ovr) begin
                errors++;
                $display("FAIL overrun t=%0t got %b want %b", $time, overrun, m_ovr);
            end
        end
    end

    task automatic step(input logic rs, input logic rv, input logic [7:0] rd,
                        input logic tv, input logic [7:0] td);
        rst      = rs;
        rx_valid = rv;
        rx_data  = rd;
        tx_load  = tv;
        tx_data  = td;
        @(posedge src_clk);
        @(negedge src_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic expect_out(input string nm, input logic em,
                              input logic [7:0] eb, input logic eo);
        checks++;
        if (mode !== em || msg !== eb || overrun !== eo || data_busy !== em) begin
            errors++;
            $display("FAIL %s got mode=%b msg=%h ovr=%b busy=%b want mode=%b msg=%h ovr=%b",
                     nm, mode, msg, overrun, data_busy, em, eb, eo);
        end
    endtask

    initial begin
        @(negedge src_clk);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        expect_out("reset", BAUD_M, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            expect_out("baud_idle", BAUD_M, 8'h01, 1'b0);
        end

        step(1'b0, 1'b1, 8'h41, 1'b0, 8'h00);
        expect_out("single_first", DATA_M, 8'h41, 1'b0);
        idle(3);
        expect_out("single_last", DATA_M, 8'h41, 1'b0);
        idle(1);
        expect_out("single_back", BAUD_M, 8'h01, 1'b0);

        step(1'b0, 1'b1, 8'h31, 1'b1, 8'h32);
        expect_out("both_rx", DATA_M, 8'h31, 1'b0);
        idle(3);
        expect_out("both_rx_end", DATA_M, 8'h31, 1'b0);
        idle(1);
        expect_out("both_tx", DATA_M, 8'h32, 1'b0);
        idle(3);
        expect_out("both_tx_end", DATA_M, 8'h32, 1'b0);
        idle(1);
        expect_out("both_back", BAUD_M, 8'h01, 1'b0);

        step(1'b0, 1'b1, 8'hA0, 1'b0, 8'h00);
        expect_out("tri_a0", DATA_M, 8'hA0, 1'b0);
        step(1'b0, 1'b1, 8'hA1, 1'b0, 8'h00);
        expect_out("tri_a1", DATA_M, 8'hA0, 1'b0);
        step(1'b0, 1'b1, 8'hA2, 1'b0, 8'h00);
        expect_out("tri_ovr", DATA_M, 8'hA0, 1'b1);
        idle(1);
        expect_out("tri_ovr_end", DATA_M, 8'hA0, 1'b0);
        idle(1);
        expect_out("tri_a2", DATA_M, 8'hA2, 1'b0);
        idle(4);
        expect_out("tri_back", BAUD_M, 8'h01, 1'b0);

        step(1'b0, 1'b1, 8'h42, 1'b0, 8'h00);
        idle(3);
        expect_out("exp_hold", DATA_M, 8'h42, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
        expect_out("exp_reload", DATA_M, 8'h55, 1'b0);
        idle(3);
        expect_out("exp_55_end", DATA_M, 8'h55, 1'b0);
        idle(1);
        expect_out("exp_back", BAUD_M, 8'h01, 1'b0);

        step(1'b0, 1'b1, 8'h61, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h62, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h63, 1'b0, 8'h00);
        expect_out("rst_mid", BAUD_M, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            expect_out("rst_after", BAUD_M, 8'h01, 1'b0);
        end

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) baud_sel = 2'($urandom_range(0, 2));
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < 20, 8'($urandom),
                 $urandom_range(0, 99) < 15, 8'($urandom));
        end
        idle(2 * HOLD + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
